// File: rtl/riscv_uart_pkg.sv
// Shared constants, register map and FSM encodings for the memory-mapped UART.
package riscv_uart_pkg;

    // Register offsets, selected by addr[3:2]
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_RXDATA  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_BAUDDIV = 2'd3;

    // STATUS bit indices
    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_FULL   = 2;
    localparam int ST_RX_VALID  = 3;
    localparam int ST_OVERRUN   = 4;
    localparam int ST_FRAME_ERR = 5;
    localparam int ST_TX_BUSY   = 6;
    localparam int ST_WIDTH     = 7;

    // Smallest usable divisor: RX needs DIV/2-1 >= 1 for its half-bit wait
    localparam logic [15:0] MIN_DIV = 16'd4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/riscv_uart_fifo.sv
// Small synchronous FIFO with show-ahead head, used for both TX and RX bytes.
module riscv_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_pop;
    logic             w_do_push;

    // Pointers carry one extra wrap bit, so count is a plain difference
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (o_count == (AW+1)'(DEPTH));
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];
    // A pop frees a slot on the same edge, so push-while-full is accepted then
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage write, no reset needed on data
    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    // Pointer update
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/riscv_uart.sv
// Memory-mapped 8N1 UART: register decode, TX/RX FIFOs and bit-level shifters.
module riscv_uart
    import riscv_uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 434
) (
    input  logic        clk,
    input  logic        arst,
    input  logic [31:0] uart_addr,
    input  logic [31:0] uart_data_in,
    input  logic        uart_configure,
    input  logic        uart_ren,
    output logic [31:0] uart_data_out,
    output logic        uart_txd,
    input  logic        uart_rxd
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]          w_sel;
    logic                w_rd;
    logic                w_tx_push;
    logic                w_rx_pop;
    logic                w_stat_rd;
    logic [7:0]          w_tx_head;
    logic [7:0]          w_rx_head;
    logic                w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [CW-1:0]       w_tx_count, w_rx_count;
    logic                w_tx_load;
    logic                w_rx_smp_stop;
    logic                w_rx_push, w_rx_ferr, w_rx_ovr;
    logic [ST_WIDTH-1:0] w_status;
    logic [31:0]         w_rd_data;
    logic                w_unused;

    logic [15:0] r_div;
    logic [31:0] r_data_out;
    logic        r_overrun, r_frame_err;

    tx_state_t   r_tx_state;
    logic        r_txd;
    logic [15:0] r_tx_cnt, r_tx_div;
    logic [7:0]  r_tx_shift;
    logic [2:0]  r_tx_bit;

    rx_state_t   r_rx_state;
    logic        r_rx_meta, r_rx_sync, r_rx_prev;
    logic [15:0] r_rx_cnt, r_rx_div;
    logic [7:0]  r_rx_shift;
    logic [2:0]  r_rx_bit;

    // Bus decode; a simultaneous write suppresses the read side effects
    assign w_sel     = uart_addr[3:2];
    assign w_rd      = uart_ren && !uart_configure;
    assign w_tx_push = uart_configure && (w_sel == REG_TXDATA);
    assign w_rx_pop  = w_rd && (w_sel == REG_RXDATA);
    assign w_stat_rd = w_rd && (w_sel == REG_STATUS);

    // TX pops from IDLE, or straight out of the last STOP cycle for gapless frames
    assign w_tx_load = !w_tx_empty &&
                       ((r_tx_state == TX_IDLE) || (r_tx_state == TX_STOP && r_tx_cnt == 16'd0));

    // Stop-bit sample outcome
    assign w_rx_smp_stop = (r_rx_state == RX_STOP) && (r_rx_cnt == 16'd0);
    assign w_rx_ferr     = w_rx_smp_stop && !r_rx_sync;
    assign w_rx_ovr      = w_rx_smp_stop && r_rx_sync && w_rx_full;
    assign w_rx_push     = w_rx_smp_stop && r_rx_sync && !w_rx_full;

    riscv_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .arst    (arst),
        .i_push  (w_tx_push),
        .i_wdata (uart_data_in[7:0]),
        .i_pop   (w_tx_load),
        .o_rdata (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    riscv_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .arst    (arst),
        .i_push  (w_rx_push),
        .i_wdata (r_rx_shift),
        .i_pop   (w_rx_pop),
        .o_rdata (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    // STATUS word assembly
    always_comb begin
        w_status               = '0;
        w_status[ST_TX_FULL]   = w_tx_full;
        w_status[ST_TX_EMPTY]  = w_tx_empty;
        w_status[ST_RX_FULL]   = w_rx_full;
        w_status[ST_RX_VALID]  = !w_rx_empty;
        w_status[ST_OVERRUN]   = r_overrun;
        w_status[ST_FRAME_ERR] = r_frame_err;
        w_status[ST_TX_BUSY]   = (r_tx_state != TX_IDLE);
    end

    // Read data mux
    always_comb begin
        w_rd_data = '0;
        case (w_sel)
            REG_RXDATA:  if (!w_rx_empty) w_rd_data = {24'b0, w_rx_head};
            REG_STATUS:  w_rd_data = {25'b0, w_status};
            REG_BAUDDIV: w_rd_data = {16'b0, r_div};
            default:     w_rd_data = '0;
        endcase
    end

    // Divisor register and registered read data
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_div      <= 16'(DEFAULT_DIV);
            r_data_out <= '0;
        end else begin
            if (uart_configure && w_sel == REG_BAUDDIV)
                r_div <= clamp_div(uart_data_in[15:0]);
            if (uart_ren)
                r_data_out <= uart_configure ? 32'd0 : w_rd_data;
        end
    end

    // Sticky error flags: a new event on the clearing edge still wins
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_stat_rd) begin
                r_overrun   <= 1'b0;
                r_frame_err <= 1'b0;
            end
            if (w_rx_ovr)  r_overrun   <= 1'b1;
            if (w_rx_ferr) r_frame_err <= 1'b1;
        end
    end

    // TX shifter: start, 8 data bits LSB first, stop; each bit r_tx_div clocks
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_tx_state <= TX_IDLE;
            r_txd      <= 1'b1;
            r_tx_cnt   <= '0;
            r_tx_div   <= 16'(DEFAULT_DIV);
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
        end else if (w_tx_load) begin
            r_tx_state <= TX_START;
            r_txd      <= 1'b0;
            r_tx_shift <= w_tx_head;
            r_tx_div   <= r_div;
            r_tx_cnt   <= r_div - 16'd1;
        end else begin
            case (r_tx_state)
                TX_IDLE: r_txd <= 1'b1;
                TX_START: begin
                    if (r_tx_cnt == 16'd0) begin
                        r_tx_state <= TX_DATA;
                        r_txd      <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= '0;
                        r_tx_cnt   <= r_tx_div - 16'd1;
                    end else r_tx_cnt <= r_tx_cnt - 16'd1;
                end
                TX_DATA: begin
                    if (r_tx_cnt == 16'd0) begin
                        r_tx_cnt <= r_tx_div - 16'd1;
                        if (r_tx_bit == 3'd7) begin
                            r_tx_state <= TX_STOP;
                            r_txd      <= 1'b1;
                        end else begin
                            r_txd      <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_bit   <= r_tx_bit + 3'd1;
                        end
                    end else r_tx_cnt <= r_tx_cnt - 16'd1;
                end
                TX_STOP: begin
                    if (r_tx_cnt == 16'd0) r_tx_state <= TX_IDLE;
                    else                   r_tx_cnt   <= r_tx_cnt - 16'd1;
                end
            endcase
        end
    end

    // RX synchroniser plus previous-value flop for falling-edge detect
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= uart_rxd;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // RX sampler: half-bit wait to centre, then one sample per bit period
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_div   <= 16'(DEFAULT_DIV);
            r_rx_shift <= '0;
            r_rx_bit   <= '0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= RX_START;
                        r_rx_div   <= r_div;
                        r_rx_cnt   <= (r_div >> 1) - 16'd1;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == 16'd0) begin
                        if (r_rx_sync) r_rx_state <= RX_IDLE;
                        else begin
                            r_rx_state <= RX_DATA;
                            r_rx_bit   <= '0;
                            r_rx_cnt   <= r_rx_div - 16'd1;
                        end
                    end else r_rx_cnt <= r_rx_cnt - 16'd1;
                end
                RX_DATA: begin
                    if (r_rx_cnt == 16'd0) begin
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_cnt   <= r_rx_div - 16'd1;
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                        else                  r_rx_bit   <= r_rx_bit + 3'd1;
                    end else r_rx_cnt <= r_rx_cnt - 16'd1;
                end
                RX_STOP: begin
                    if (r_rx_cnt == 16'd0) r_rx_state <= RX_IDLE;
                    else                   r_rx_cnt   <= r_rx_cnt - 16'd1;
                end
            endcase
        end
    end

    assign uart_data_out = r_data_out;
    assign uart_txd      = r_txd;

    // Address/data bits outside the decoded fields and FIFO counts are not needed here
    assign w_unused = ^{uart_addr[31:4], uart_addr[1:0], uart_data_in[31:16], w_tx_count, w_rx_count};

endmodule

// File: tb/tb_riscv_uart.sv
// Self-checking bench for riscv_uart: register map, TX framing, RX, errors, reset.
module tb_riscv_uart;
    import riscv_uart_pkg::*;

    logic        clk = 1'b0;
    logic        arst;
    logic [31:0] uart_addr;
    logic [31:0] uart_data_in;
    logic        uart_configure;
    logic        uart_ren;
    logic [31:0] uart_data_out;
    logic        uart_txd;
    logic        uart_rxd;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_uart #(.FIFO_DEPTH(8), .DEFAULT_DIV(434)) dut (
        .clk            (clk),
        .arst           (arst),
        .uart_addr      (uart_addr),
        .uart_data_in   (uart_data_in),
        .uart_configure (uart_configure),
        .uart_ren       (uart_ren),
        .uart_data_out  (uart_data_out),
        .uart_txd       (uart_txd),
        .uart_rxd       (uart_rxd)
    );

    always #5 clk = ~clk;

    // Address with random undecoded bits around the register index
    function automatic logic [31:0] mk_addr(input logic [1:0] r);
        logic [31:0] a;
        a = $urandom();
        a[3:2] = r;
        return a;
    endfunction

    task automatic bus_write(input logic [1:0] r, input logic [31:0] d);
        @(negedge clk);
        uart_addr = mk_addr(r); uart_data_in = d; uart_configure = 1'b1;
        @(negedge clk);
        uart_configure = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
        @(negedge clk);
        uart_addr = mk_addr(r); uart_ren = 1'b1;
        @(negedge clk);
        uart_ren = 1'b0;
        d = uart_data_out;
    endtask

    // Drive one serial frame on rxd, then idle high for two bit times
    task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
        logic [9:0] frm;
        frm = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); uart_rxd = frm[k];
            repeat (div - 1) @(negedge clk);
        end
        @(negedge clk); uart_rxd = 1'b1;
        repeat (2 * div) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        arst = 1'b1; uart_addr = '0; uart_data_in = '0;
        uart_configure = 1'b0; uart_ren = 1'b0; uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        arst = 1'b0;
        n_checks++; if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", uart_txd); end
        n_checks++; if (uart_data_out !== 32'd0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", uart_data_out); end
        bus_read(REG_BAUDDIV, d);
        n_checks++; if (d !== 32'd434) begin n_fail++; $display("FAIL reset_div: got %0d want 434", d); end
        bus_read(REG_STATUS, d);
        n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL reset_status: got %h want 02", d); end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        int dv;
        bus_write(REG_BAUDDIV, 32'd2);
        bus_read(REG_BAUDDIV, d);
        n_checks++; if (d !== 32'd4) begin n_fail++; $display("FAIL div_clamp: got %0d want 4", d); end
        dv = $urandom_range(5, 300);
        bus_write(REG_BAUDDIV, 32'hABCD_0000 | 32'(dv));
        bus_read(REG_BAUDDIV, d);
        n_checks++; if (d !== 32'(dv)) begin n_fail++; $display("FAIL div_rw: got %0d want %0d", d, dv); end
        bus_read(REG_TXDATA, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL txdata_read: got %h want 0", d); end
        bus_write(REG_STATUS, 32'hFF);
        bus_write(REG_RXDATA, 32'h5A);
        bus_read(REG_STATUS, d);
        n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL ro_write: got %h want 02", d); end
        // Write and read together: write lands, read yields zero
        @(negedge clk);
        uart_addr = mk_addr(REG_BAUDDIV); uart_data_in = 32'd6;
        uart_configure = 1'b1; uart_ren = 1'b1;
        @(negedge clk);
        uart_configure = 1'b0; uart_ren = 1'b0;
        n_checks++; if (uart_data_out !== 32'd0) begin n_fail++; $display("FAIL wr_rd_same: got %h want 0", uart_data_out); end
        bus_read(REG_BAUDDIV, d);
        n_checks++; if (d !== 32'd6) begin n_fail++; $display("FAIL wr_rd_div: got %0d want 6", d); end
    endtask

    // One byte out; per-cycle line level and busy flag against the ideal frame
    task automatic test_tx_frame(input logic [7:0] b, input int div);
        logic [9:0] frm;
        frm = {1'b1, b, 1'b0};
        bus_write(REG_BAUDDIV, 32'(div));
        bus_write(REG_TXDATA, {24'hFFFFFF, b});
        uart_addr = mk_addr(REG_STATUS); uart_ren = 1'b1;
        for (int i = 0; i < 10 * div; i++) begin
            @(negedge clk);
            n_checks++;
            if (uart_txd !== frm[i / div]) begin
                n_fail++; $display("FAIL tx_bit[%0d] byte %h: got %b want %b", i, b, uart_txd, frm[i / div]);
            end
            if (i >= 1) begin
                n_checks++;
                if (uart_data_out[ST_TX_BUSY] !== 1'b1) begin
                    n_fail++; $display("FAIL tx_busy[%0d]: got %b want 1", i, uart_data_out[ST_TX_BUSY]);
                end
            end
        end
        @(negedge clk);
        @(negedge clk);
        uart_ren = 1'b0;
        n_checks++; if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL tx_idle: got %b want 1", uart_txd); end
        n_checks++; if (uart_data_out !== 32'h02) begin n_fail++; $display("FAIL tx_done_status: got %h want 02", uart_data_out); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [10];
        logic       exp_bits [$];
        logic [9:0] frm;
        logic [31:0] d;
        int bad_idle;
        for (int k = 0; k < 10; k++) bytes[k] = 8'($urandom());
        for (int k = 0; k < 9; k++) begin
            frm = {1'b1, bytes[k], 1'b0};
            for (int j = 0; j < 40; j++) exp_bits.push_back(frm[j / 4]);
        end
        bus_write(REG_BAUDDIV, 32'd4);
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    uart_addr = mk_addr(REG_TXDATA); uart_data_in = {24'd0, bytes[k]};
                    uart_configure = 1'b1;
                end
                @(negedge clk);
                uart_configure = 1'b0;
                bus_read(REG_STATUS, d);
                n_checks++; if (d !== 32'h41) begin n_fail++; $display("FAIL b2b_status: got %h want 41", d); end
            end
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 360; i++) begin
                    @(negedge clk);
                    n_checks++;
                    if (uart_txd !== exp_bits[i]) begin
                        n_fail++; $display("FAIL b2b_bit[%0d]: got %b want %b", i, uart_txd, exp_bits[i]);
                    end
                end
                bad_idle = 0;
                for (int i = 0; i < 60; i++) begin
                    @(negedge clk);
                    if (uart_txd !== 1'b1) bad_idle++;
                end
                n_checks++; if (bad_idle != 0) begin n_fail++; $display("FAIL b2b_dropped: got %0d low cycles want 0", bad_idle); end
            end
        join
        bus_read(REG_STATUS, d);
        n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL b2b_end_status: got %h want 02", d); end
    endtask

    task automatic test_rx_basic();
        logic [31:0] d;
        logic [7:0]  b;
        bus_write(REG_BAUDDIV, 32'd8);
        send_rx(8'hA3, 1'b1, 8);
        bus_read(REG_STATUS, d);
        n_checks++; if (d !== 32'h0A) begin n_fail++; $display("FAIL rx_status: got %h want 0A", d); end
        bus_read(REG_RXDATA, d);
        n_checks++; if (d !== 32'h000000A3) begin n_fail++; $display("FAIL rx_data: got %h want A3", d); end
        bus_read(REG_STATUS, d);
        n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL rx_drained: got %h want 02", d); end
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom());
            send_rx(b, 1'b1, 8);
            bus_read(REG_RXDATA, d);
            n_checks++; if (d !== {24'd0, b}) begin n_fail++; $display("FAIL rx_rand: got %h want %h", d, b); end
        end
    endtask

    task automatic test_frame_err();
        logic [31:0] d;
        send_rx(8'($urandom()), 1'b0, 8);
        bus_read(REG_STATUS, d);
        n_checks++; if (d !== 32'h22) begin n_fail++; $display("FAIL ferr_set: got %h want 22", d); end
        bus_read(REG_STATUS, d);
        n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL ferr_clear: got %h want 02", d); end
    endtask

    task automatic test_overrun();
        logic [7:0]  q [$];
        logic [7:0]  b;
        logic [31:0] d, exp;
        logic        ovr;
        ovr = 1'b0;
        for (int k = 0; k < 9; k++) begin
            b = 8'($urandom());
            send_rx(b, 1'b1, 8);
            if (q.size() < 8) q.push_back(b); else ovr = 1'b1;
        end
        exp = 32'h02 | (q.size() != 0 ? 32'h08 : 32'h0) | (q.size() == 8 ? 32'h04 : 32'h0) | (ovr ? 32'h10 : 32'h0);
        bus_read(REG_STATUS, d);
        n_checks++; if (d !== exp) begin n_fail++; $display("FAIL ovr_status: got %h want %h", d, exp); end
        for (int k = 0; k < 9; k++) begin
            exp = (q.size() != 0) ? {24'd0, q.pop_front()} : 32'd0;
            bus_read(REG_RXDATA, d);
            n_checks++; if (d !== exp) begin n_fail++; $display("FAIL ovr_read[%0d]: got %h want %h", k, d, exp); end
        end
        bus_read(REG_STATUS, d);
        n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL ovr_end: got %h want 02", d); end
    endtask

    task automatic test_reset_mid_tx();
        logic [31:0] d;
        bus_write(REG_BAUDDIV, 32'd4);
        bus_write(REG_TXDATA, 32'h00);
        repeat (10) @(negedge clk);
        n_checks++; if (uart_txd !== 1'b0) begin n_fail++; $display("FAIL midtx_low: got %b want 0", uart_txd); end
        #2 arst = 1'b1;
        #1;
        n_checks++; if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL arst_txd: got %b want 1", uart_txd); end
        @(negedge clk);
        arst = 1'b0;
        bus_read(REG_STATUS, d);
        n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL arst_status: got %h want 02", d); end
        bus_read(REG_BAUDDIV, d);
        n_checks++; if (d !== 32'd434) begin n_fail++; $display("FAIL arst_div: got %0d want 434", d); end
        n_checks++; if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL arst_idle: got %b want 1", uart_txd); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_tx_frame(8'h55, 4);
        for (int k = 0; k < 3; k++) test_tx_frame(8'($urandom()), $urandom_range(4, 7));
        test_back_to_back();
        test_rx_basic();
        test_frame_err();
        test_overrun();
        test_reset_mid_tx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
